moore_run_detector: RTL and testbench

Parametrised Moore-style run detector: asserts `z` once input `w` has held the selected target level for `RUN_LEN` consecutive enabled clock cycles. It generalises the fixed two-cycle "w high twice" detector with:
- configurable run length;
- a ones/zeros detection mode;
- a clock enable;
- a one-cycle detection pulse and a saturating detection counter.

It sits in the state_machine library as the general-purpose sequence/run qualifier for debounce, framing and watchdog-style logic.

---
 rtl/moore_run_detector.sv | 90 +++++++++
 tb/tb_moore_run_detector.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/moore_run_detector.sv
// moore_run_detector: Moore-style run detector. Raises z once w has held the
// target level (ones when Mode=0, zeros when Mode=1) for RUN_LEN consecutive
// enabled samples. It also emits a one-cycle pulse on each new detection and
// keeps a saturating count of detections.
module moore_run_detector #(
    parameter  int RUN_LEN = 2,
    parameter  int CNT_W   = 8,
    localparam int RW      = $clog2(RUN_LEN + 1)
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             En,
    input  logic             Mode,
    input  logic             Clr,
    input  logic             w,
    output logic             z,
    output logic             pulse,
    output logic [CNT_W-1:0] count,
    output logic [RW-1:0]    run
);

    localparam logic [RW-1:0]    RUN_MAX = RW'(RUN_LEN);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             mode_q;
    logic             mode_d;
    logic [RW-1:0]    run_d;
    logic             pulse_d;
    logic [CNT_W-1:0] count_d;
    logic             detect;

    // State register: synchronous reset, then load the next-state values.
    // NOTE: sequential state uses non-blocking (<=) so that every register
    // samples the values from before this edge, regardless of statement order.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            run    <= '0;
            mode_q <= Mode;
            pulse  <= 1'b0;
            count  <= '0;
        end else begin
            run    <= run_d;
            mode_q <= mode_d;
            pulse  <= pulse_d;
            count  <= count_d;
        end
    end

    // Next-state logic: a mode change restarts the run, a disabled cycle holds
    // it, otherwise a matching sample extends it and a mismatch clears it.
    always_comb begin
        // NOTE: every signal assigned here gets a default first; a path that
        // left one unassigned would infer a latch.
        run_d   = run;
        mode_d  = mode_q;
        pulse_d = 1'b0;
        count_d = count;
        detect  = 1'b0;

        if (Mode != mode_q) begin
            // The sample taken on the toggle edge is discarded.
            mode_d = Mode;
            run_d  = '0;
        end else if (En) begin
            if (w == ~mode_q) begin
                run_d = (run == RUN_MAX) ? RUN_MAX : run + 1'b1;
            end else begin
                run_d = '0;
            end
        end

        // A detection fires only when the run reaches RUN_LEN from below,
        // so a sustained run does not fire again.
        detect  = (run_d == RUN_MAX) && (run != RUN_MAX);
        pulse_d = detect;

        // Clear takes priority over a detection on the same edge.
        if (Clr) begin
            count_d = '0;
        end else if (detect && (count != CNT_MAX)) begin
            count_d = count + 1'b1;
        end
    end

    // Output decode: z depends on the registered run length only.
    always_comb begin
        z = (run == RUN_MAX);
    end

endmodule

// File: tb/tb_moore_run_detector.sv
// Testbench for moore_run_detector: three instances (RUN_LEN/CNT_W = 2/8,
// 4/3 and 1/2) share one stimulus stream and are checked every cycle against
// a streak-counting reference model. Directed scenarios are followed by a
// randomized phase.
module tb_moore_run_detector;

    logic Clock = 1'b0;
    logic Reset, En, Mode, Clr, w;

    logic       z2, p2;
    logic [7:0] c2;
    logic [1:0] r2;

    logic       z4, p4;
    logic [2:0] c4;
    logic [2:0] r4;

    logic       z1, p1;
    logic [1:0] c1;
    logic [0:0] r1;

    moore_run_detector #(.RUN_LEN(2), .CNT_W(8)) u2 (
        .Clock(Clock), .Reset(Reset), .En(En), .Mode(Mode), .Clr(Clr), .w(w),
        .z(z2), .pulse(p2), .count(c2), .run(r2)
    );
    moore_run_detector #(.RUN_LEN(4), .CNT_W(3)) u4 (
        .Clock(Clock), .Reset(Reset), .En(En), .Mode(Mode), .Clr(Clr), .w(w),
        .z(z4), .pulse(p4), .count(c4), .run(r4)
    );
    moore_run_detector #(.RUN_LEN(1), .CNT_W(2)) u1 (
        .Clock(Clock), .Reset(Reset), .En(En), .Mode(Mode), .Clr(Clr), .w(w),
        .z(z1), .pulse(p1), .count(c1), .run(r1)
    );

    always #5 Clock = ~Clock;

    int total = 0;
    int bad   = 0;

    // Reference model: an unbounded streak of matching enabled samples per
    // instance. z means the streak has reached L, and run is the streak
    // clipped to L.
    int L   [3] = '{2, 4, 1};
    int CAP [3] = '{255, 7, 3};
    int st  [3];
    int cm  [3];
    bit pm  [3];
    bit mode_m;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_update();
        bit old_mode = mode_m;
        if (Reset) begin
            mode_m = Mode;
            for (int i = 0; i < 3; i++) begin
                st[i] = 0; cm[i] = 0; pm[i] = 0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                int  old = st[i];
                bit  det;
                if (Mode != old_mode)  st[i] = 0;
                else if (En)           st[i] = (w != old_mode) ? st[i] + 1 : 0;
                det   = (st[i] >= L[i]) && (old < L[i]);
                pm[i] = det;
                if (Clr)                    cm[i] = 0;
                else if (det && cm[i] < CAP[i]) cm[i] = cm[i] + 1;
            end
            mode_m = Mode;
        end
    endtask

    function automatic int exp_run(int i);
        return (st[i] < L[i]) ? st[i] : L[i];
    endfunction

    function automatic int exp_z(int i);
        return (st[i] >= L[i]) ? 1 : 0;
    endfunction

    task automatic check_model();
        check("u2.run",   r2, exp_run(0));
        check("u2.z",     z2, exp_z(0));
        check("u2.pulse", p2, pm[0]);
        check("u2.count", c2, cm[0]);
        check("u4.run",   r4, exp_run(1));
        check("u4.z",     z4, exp_z(1));
        check("u4.pulse", p4, pm[1]);
        check("u4.count", c4, cm[1]);
        check("u1.run",   r1, exp_run(2));
        check("u1.z",     z1, exp_z(2));
        check("u1.pulse", p1, pm[2]);
        check("u1.count", c1, cm[2]);
    endtask

    // One clock: apply inputs, update the model at the edge, check 1 time unit later.
    task automatic step(input logic rst_i, input logic mode_i, input logic en_i,
                        input logic clr_i, input logic w_i);
        Reset = rst_i; Mode = mode_i; En = en_i; Clr = clr_i; w = w_i;
        @(posedge Clock);
        model_update();
        #1;
        check_model();
    endtask

    initial begin
        int exp_r [5] = '{1, 2, 2, 2, 0};
        int exp_zz[5] = '{0, 1, 1, 1, 0};
        int exp_p [5] = '{0, 1, 0, 0, 0};
        int en_seq[6] = '{1, 0, 1, 0, 1, 1};
        logic mode_r;

        Reset = 1'b1; Mode = 1'b0; En = 1'b0; Clr = 1'b0; w = 1'b0;
        mode_m = 1'b0;
        for (int i = 0; i < 3; i++) begin
            st[i] = 0; cm[i] = 0; pm[i] = 0;
        end

        // Reset for two cycles, then idle with w=0 in ones mode.
        step(1, 0, 1, 0, 0);
        step(1, 0, 1, 0, 0);
        check("reset.z",     z2, 0);
        check("reset.pulse", p2, 0);
        check("reset.count", c2, 0);
        check("reset.run",   r2, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 1, 0, 0);

        // Run of ones 1,1,1,1,0 against the default RUN_LEN=2 instance.
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 1, 0, (i < 4) ? 1'b1 : 1'b0);
            check("ones.run",   r2, exp_r[i]);
            check("ones.z",     z2, exp_zz[i]);
            check("ones.pulse", p2, exp_p[i]);
        end
        check("ones.count", c2, 1);

        // Switch to zeros mode, then feed w=0 with enable gaps.
        step(0, 1, 1, 0, 0);
        for (int i = 0; i < 6; i++) step(0, 1, en_seq[i][0], 0, 0);
        check("zeros.z4", z4, 1);
        check("zeros.p4", p4, 1);
        step(0, 1, 0, 0, 0);
        check("zeros.p4_one_cycle", p4, 0);
        check("zeros.z4_held",      z4, 1);
        step(0, 1, 1, 0, 1);
        check("zeros.z4_drop", z4, 0);

        // Mode toggle mid-run: ones mode, w=1 twice, toggle with w=0, then zeros.
        step(0, 0, 1, 0, 0);
        step(0, 0, 1, 0, 1);
        step(0, 0, 1, 0, 1);
        check("toggle.pre_run4", r4, 2);
        step(0, 1, 1, 0, 0);
        check("toggle.cleared_run4", r4, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 1, 0, 0);
        check("toggle.run4", r4, 3);
        check("toggle.z4",   z4, 0);

        // Saturation of the 2-bit counter with RUN_LEN=1: alternate w in ones mode.
        step(1, 0, 1, 0, 0);
        for (int i = 0; i < 10; i++) step(0, 0, 1, 0, i[0] ? 1'b0 : 1'b1);
        check("sat.c1", c1, 3);
        step(0, 0, 1, 1, 1);
        check("clr.c1", c1, 0);
        check("clr.p1", p1, 1);

        // Randomized phase.
        mode_r = Mode;
        for (int n = 0; n < 600; n++) begin
            logic rst_r, en_r, clr_r, w_r;
            if ($urandom_range(99) < 3) mode_r = ~mode_r;
            rst_r = ($urandom_range(199) == 0);
            en_r  = ($urandom_range(99) < 80);
            clr_r = ($urandom_range(99) < 3);
            w_r   = ($urandom_range(99) < 80) ? ~mode_r : mode_r;
            step(rst_r, mode_r, en_r, clr_r, w_r);
        end

        // Reset mid-run with z=1 and count=5 on the default instance.
        step(1, 0, 1, 0, 0);
        for (int k = 0; k < 4; k++) begin
            step(0, 0, 1, 0, 1);
            step(0, 0, 1, 0, 1);
            step(0, 0, 1, 0, 0);
        end
        step(0, 0, 1, 0, 1);
        step(0, 0, 1, 0, 1);
        check("pre_rst.z",     z2, 1);
        check("pre_rst.count", c2, 5);
        step(1, 0, 1, 0, 1);
        check("mid_rst.z",     z2, 0);
        check("mid_rst.run",   r2, 0);
        check("mid_rst.count", c2, 0);
        check("mid_rst.pulse", p2, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
